net_cmd_unit: RTL

Network command unit for the next-generation core tile: it accepts network packets, filters them by core ID or broadcast, and buffers matching packets in a small FIFO. Each buffered command is dispatched to the core's PC, instruction memory, register file or barrier-mask ports only when the core can take it. A register read-back command returns a reply packet. It replaces the fixed, unbuffered ID-match decode inside the core, and it is parametrised in ID, address, data and buffer widths.

---
 rtl/net_cmd_unit_pkg.sv | 32 +++
 rtl/net_cmd_fifo.sv | 60 ++++++
 rtl/net_cmd_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/net_cmd_unit_pkg.sv
// Shared types for the network command unit: opcodes, FSM states, broadcast ID.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package net_cmd_unit_pkg;

    // Network command opcodes; codes 6 and 7 are unassigned and never buffered
    typedef enum logic [2:0] {
        NET_OP_NULL   = 3'd0,
        NET_OP_PC     = 3'd1,
        NET_OP_INSTR  = 3'd2,
        NET_OP_REG    = 3'd3,
        NET_OP_BAR    = 3'd4,
        NET_OP_RD_REG = 3'd5
    } net_op_e;

    // Dispatcher states
    typedef enum logic [1:0] {
        ST_DISPATCH = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_REPLY    = 2'd2
    } net_cmd_state_e;

    // All-ones broadcast ID; users slice the low id_width bits (id width up to 32)
    localparam int                            NET_ID_MAX_WIDTH = 32;
    localparam logic [NET_ID_MAX_WIDTH-1:0]   NET_BCAST_ID     = '1;

    // True for opcodes that carry a command worth buffering
    function automatic logic net_op_known(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

endpackage

// File: rtl/net_cmd_fifo.sv
// Generic valid/ready FIFO holding buffered network commands.
// Latency: one cycle from push to visibility at the head (no bypass).
// Backpressure: in_rdy drops when full, even if a pop happens the same cycle.
module net_cmd_fifo #(
    parameter int width_p = 8,
    parameter int depth_p = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [width_p-1:0] in_dat,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [width_p-1:0] out_dat
);
    localparam int ptr_w_lp = $clog2(depth_p);

    logic [width_p-1:0]  mem [depth_p];
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [ptr_w_lp-1:0] rd_ptr;
    logic [ptr_w_lp:0]   count;
    logic                push;
    logic                pop;

    assign in_rdy  = (count != (ptr_w_lp+1)'(depth_p));
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w_lp'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w_lp'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ptr_w_lp+1)'(1);
                2'b01:   count <= count - (ptr_w_lp+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/net_cmd_unit.sv
// Filters network packets by core ID/broadcast, buffers commands, dispatches them to core ports.
// Latency: accepted packet dispatches no earlier than the next cycle; RD_REG reply valid 2 cycles after rf_rd_en_o.
// Backpressure: pkt_ready_o = !full; the head is held while its target port is busy or a reply is pending.
module net_cmd_unit
    import net_cmd_unit_pkg::*;
#(
    parameter int                    id_width_p    = 10,
    parameter logic [id_width_p-1:0] net_ID_p      = 10'b0000000001,
    parameter int                    addr_width_p  = 10,
    parameter int                    data_width_p  = 32,
    parameter int                    fifo_depth_p  = 4,
    parameter int                    mask_length_p = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pkt_valid_i,
    input  logic [id_width_p-1:0]   pkt_id_i,
    input  logic [2:0]              pkt_op_i,
    input  logic [addr_width_p-1:0] pkt_add_i,
    input  logic [data_width_p-1:0] pkt_data_i,
    output logic                    pkt_ready_o,
    input  logic                    core_idle_i,
    input  logic                    core_err_i,
    input  logic                    imem_free_i,
    input  logic                    rf_free_i,
    output logic                    pc_wen_o,
    output logic                    imem_wen_o,
    output logic                    rf_wen_o,
    output logic                    bar_wen_o,
    output logic                    rf_rd_en_o,
    output logic [addr_width_p-1:0] cmd_add_o,
    output logic [data_width_p-1:0] cmd_data_o,
    input  logic [data_width_p-1:0] rf_rd_data_i,
    output logic                    reply_valid_o,
    input  logic                    reply_ready_i,
    output logic [id_width_p-1:0]   reply_id_o,
    output logic [addr_width_p-1:0] reply_add_o,
    output logic [data_width_p-1:0] reply_data_o,
    output logic                    exception_o,
    output logic [7:0]              drop_count_o
);
    typedef struct packed {
        net_op_e                 op;
        logic [addr_width_p-1:0] add;
        logic [data_width_p-1:0] data;
    } cmd_t;

    cmd_t           push_cmd;
    cmd_t           head;
    logic           fifo_in_rdy;
    logic           fifo_out_vld;
    logic           pop;
    logic           is_bcast;
    logic           is_match;
    logic           accept;
    logic           enq_drop;
    logic           push;
    logic           disp_drop;
    logic           set_exc;
    logic           start_rd;
    logic [1:0]     drop_inc;
    logic [8:0]     drop_sum;
    net_cmd_state_e state;

    // Intake filter: a broadcast RD_REG is consumed but never buffered
    assign is_bcast    = (pkt_id_i == NET_BCAST_ID[id_width_p-1:0]);
    assign is_match    = is_bcast || (pkt_id_i == net_ID_p);
    assign accept      = pkt_valid_i & is_match & net_op_known(pkt_op_i) & fifo_in_rdy;
    assign enq_drop    = accept & is_bcast & (pkt_op_i == NET_OP_RD_REG);
    assign push        = accept & ~enq_drop;
    assign pkt_ready_o = fifo_in_rdy;
    assign push_cmd    = '{op: net_op_e'(pkt_op_i), add: pkt_add_i, data: pkt_data_i};

    net_cmd_fifo #(
        .width_p ($bits(cmd_t)),
        .depth_p (fifo_depth_p)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (push),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (push_cmd),
        .out_vld (fifo_out_vld),
        .out_rdy (pop),
        .out_dat (head)
    );

    // Head always drives the command bus; a barrier presents only its mask bits
    assign cmd_add_o = head.add;
    always_comb begin
        cmd_data_o = head.data;
        if (head.op == NET_OP_BAR) begin
            cmd_data_o = data_width_p'(head.data[mask_length_p-1:0]);
        end
    end

    // Dispatch decode: strobe and pop together so the strobe sees its own head
    always_comb begin
        pc_wen_o   = 1'b0;
        imem_wen_o = 1'b0;
        rf_wen_o   = 1'b0;
        bar_wen_o  = 1'b0;
        rf_rd_en_o = 1'b0;
        pop        = 1'b0;
        disp_drop  = 1'b0;
        set_exc    = 1'b0;
        start_rd   = 1'b0;
        if ((state == ST_DISPATCH) && fifo_out_vld) begin
            case (head.op)
                NET_OP_PC: begin
                    pop       = 1'b1;
                    pc_wen_o  = core_idle_i;
                    set_exc   = ~core_idle_i;
                    disp_drop = ~core_idle_i;
                end
                NET_OP_INSTR: begin
                    pop        = imem_free_i;
                    imem_wen_o = imem_free_i;
                end
                NET_OP_REG: begin
                    pop      = rf_free_i;
                    rf_wen_o = rf_free_i;
                end
                NET_OP_BAR: begin
                    pop       = 1'b1;
                    bar_wen_o = ~core_err_i;
                    disp_drop = core_err_i;
                end
                NET_OP_RD_REG: begin
                    pop        = rf_free_i;
                    rf_rd_en_o = rf_free_i;
                    start_rd   = rf_free_i;
                end
                default: pop = 1'b1;
            endcase
        end
    end

    // An intake drop and a dispatch drop can land in the same cycle
    assign drop_inc = {1'b0, enq_drop} + {1'b0, disp_drop};
    assign drop_sum = {1'b0, drop_count_o} + 9'(drop_inc);

    // Read-back FSM plus sticky exception and saturating drop counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_DISPATCH;
            reply_valid_o <= 1'b0;
            reply_id_o    <= '0;
            reply_add_o   <= '0;
            reply_data_o  <= '0;
            exception_o   <= 1'b0;
            drop_count_o  <= '0;
        end else begin
            if (set_exc) begin
                exception_o <= 1'b1;
            end
            drop_count_o <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            case (state)
                ST_DISPATCH: begin
                    if (start_rd) begin
                        reply_add_o <= head.add;
                        reply_id_o  <= head.data[id_width_p-1:0];
                        state       <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    reply_data_o  <= rf_rd_data_i;
                    reply_valid_o <= 1'b1;
                    state         <= ST_REPLY;
                end
                ST_REPLY: begin
                    if (reply_ready_i) begin
                        reply_valid_o <= 1'b0;
                        state         <= ST_DISPATCH;
                    end
                end
                default: state <= ST_DISPATCH;
            endcase
        end
    end

endmodule
